fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencing controller for the instruction-fetch stage. It drives the PC register's write enable and next-PC select, handshakes with a multi-cycle instruction memory, and holds branch/jump redirect targets until the in-flight fetch completes. It squashes wrong-path instructions and stops fetch on HALT. It sits between the hazard/branch logic (execute, decode) and the fetch datapath (PC register, PC+2 adder, next-PC mux, instruction memory).

## Interface
Parameters:
- `PC_W`, 16, PC and target width.
- `NOP_INSTR`, 16'h0800, instruction word injected into IF/ID when a fetch is squashed or invalid.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `stall_in`  in  1  hazard unit: hold IF/ID and PC.
- `redirect_in`  in  1  taken branch/jump resolved this cycle.
- `redirect_pc`  in  PC_W  target address, valid with `redirect_in`.
- `halt_in`  in  1  HALT decoded.
- `mem_busy`  in  1  instruction memory access in progress.
- `mem_done`  in  1  instruction word valid this cycle.
- `pcwren`  out  1  PC register write enable.
- `pcselect`  out  1  1 = next PC is `redir_pc`; 0 = PC+2.
- `redir_pc`  out  PC_W  latched redirect target, feeds fetch `pcIN`.
- `mem_en`  out  1  instruction memory read enable.
- `ifid_wren`  out  1  IF/ID pipeline register write enable.
- `if_valid`  out  1  1 = pass fetched word; 0 = substitute `NOP_INSTR`.
- `halted`  out  1  fetch stopped.

## Operation
- **States:** IDLE, FETCH, HOLD, HALT.
- **Reset:** state IDLE. All outputs 0, `redir_pc` = 0, pending-redirect flag (`pend`) = 0.
- **IDLE → FETCH:** unconditional, on the next edge.
- **FETCH:**
  - `mem_en` = 1.
  - Outputs asserted only when `mem_done` = 1; otherwise `pcwren` = `ifid_wren` = 0.
- **Redirect:**
  - `redirect_in` in any non-HALT state latches `redirect_pc` into `redir_pc`.
  - If the fetch cannot complete in that same cycle, `redirect_in` also sets `pend`.
- **Fetch completion** (`mem_done` = 1, `stall_in` = 0):
  - `pcwren` = 1, `ifid_wren` = 1.
  - `pcselect` = `pend` | `redirect_in`.
  - `if_valid` = !(`pend` | `redirect_in`).
  - `pend` clears.
- **Stall:** `mem_done` = 1 with `stall_in` = 1 → HOLD.
  - The fetched word stays valid in the IF/ID input path.
  - `pcwren` = `ifid_wren` = 0, `mem_en` = 0.
- **HOLD:**
  - Stays while `stall_in` = 1.
  - On `stall_in` = 0, performs the completion actions above and returns to FETCH.
  - `redirect_in` during HOLD: the held word is squashed on release (`if_valid` = 0).
- **Priority in one cycle:** reset > redirect > halt > stall > sequential.
  - `redirect_in` with `halt_in` in the same cycle: the halt is wrong-path and is ignored.
- **Halt:**
  - `halt_in` (no redirect) → HALT after the current completion. The HALT word itself is written with `if_valid` = 1.
  - In HALT: `halted` = 1, `pcwren` = `mem_en` = `ifid_wren` = 0.
  - HALT exits only via `rst`.
- `mem_busy` = 1 with `mem_done` = 1 is treated as done.

## Timing
- **Zero-wait memory** (`mem_done` every cycle): one instruction per cycle. `pcwren` is high every cycle from the second cycle after reset release.
- **Redirect, not mid-fetch:** `pcselect` asserts in the same cycle as `redirect_in`. The target instruction is fetched starting the next cycle.
- **Redirect mid-fetch:** penalty = remaining memory latency + 1 cycle. Exactly one squashed word (`if_valid` = 0) enters IF/ID.
- **Latches:** `redir_pc` updates on the edge after `redirect_in`. The same-cycle `pcselect` path uses `redirect_pc` combinationally through the `redir_pc` output mux.
- **Halt:** `halted` rises one edge after the completion that carries the HALT.
- **Reset asserted mid-access:** immediate return to IDLE, `pend` lost, outputs 0 asynchronously.

## Configuration
- **`FETCH_CTRL_PERF_EN`** defined adds three output ports:
  - `stall_cycles`  out  16: cycles in FETCH with `mem_done` = 0, plus cycles in HOLD.
  - `squash_count`  out  16: words written with `if_valid` = 0.
  - `fetch_count`  out  16: words written with `if_valid` = 1.
- Counter behaviour: all three saturate at 16'hFFFF, reset to 0, and freeze in HALT.
- Undefined: the ports and counters are absent. Control behaviour is identical.

## Structure
- **Shared package `fetch_pkg`:** state encoding localparams (IDLE = 2'b00, FETCH = 2'b01, HOLD = 2'b10, HALT = 2'b11) and the `NOP_INSTR` constant. The decode stage reuses the constant.
- **Sub-module `fetch_perf_cnt`:** one saturating 16-bit counter, instantiated three times, present only under `FETCH_CTRL_PERF_EN`.
- All remaining logic is flat: FSM, `pend` flag, `redir_pc` register.

## Test plan
- **Zero-wait run:** tie `mem_done` = 1 for 10 cycles after `rst` release → `pcwren` high cycles 2–10, `pcselect` = 0, `if_valid` = 1. With the macro: `fetch_count` = 9.
- **Redirect mid-fetch:** 3-cycle memory latency; `redirect_in` with `redirect_pc` = 16'h0040 on cycle 1 of an access → at `mem_done`: `pcselect` = 1, `if_valid` = 0, `redir_pc` = 16'h0040. Next access is the target.
- **Stall with done:** `stall_in` = 1 for 4 cycles, starting the same cycle `mem_done` = 1 → state HOLD for 4 cycles, `pcwren` = 0, `mem_en` = 0. On release: one `ifid_wren` pulse with `if_valid` = 1.
- **Redirect and halt together:** `halt_in` = 1 and `redirect_in` = 1 in the same cycle → `halted` stays 0, `pcselect` = 1, fetch continues at the target.
- **Halt:** `halt_in` at completion → `halted` = 1 on the next edge. `pcwren` stays 0 for 20 cycles despite `mem_done` toggling.
- **Async reset mid-access:** drop `rst` while `mem_busy` = 1 and `pend` = 1 → all outputs 0 without waiting for a clock edge. After release, the first completion has `pcselect` = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding and the NOP word
// injected into IF/ID. The decode stage imports the same constant.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t IDLE  = 2'b00;
  localparam fetch_state_t FETCH = 2'b01;
  localparam fetch_state_t HOLD  = 2'b10;
  localparam fetch_state_t HALT  = 2'b11;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Control bundle between fetch_ctrl (master) and the hazard/branch logic
// plus fetch datapath (slave).
interface fetch_ctrl_if #(
  parameter int PC_W = 16
);
  logic            stall_in;
  logic            redirect_in;
  logic [PC_W-1:0] redirect_pc;
  logic            halt_in;
  logic            mem_busy;
  logic            mem_done;

  logic            pcwren;
  logic            pcselect;
  logic [PC_W-1:0] redir_pc;
  logic            mem_en;
  logic            ifid_wren;
  logic            if_valid;
  logic            halted;

  modport master (
    input  stall_in, redirect_in, redirect_pc, halt_in, mem_busy, mem_done,
    output pcwren, pcselect, redir_pc, mem_en, ifid_wren, if_valid, halted
  );

  modport slave (
    output stall_in, redirect_in, redirect_pc, halt_in, mem_busy, mem_done,
    input  pcwren, pcselect, redir_pc, mem_en, ifid_wren, if_valid, halted
  );
endinterface

// File: rtl/fetch_perf_cnt.sv
// Saturating event counter used by fetch_ctrl when FETCH_CTRL_PERF_EN is
// defined; holds at all-ones instead of wrapping.
module fetch_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: PC write/select, multi-cycle
// imem handshake, redirect holding, squash and HALT. Optional performance
// counters are compiled in with FETCH_CTRL_PERF_EN.
module fetch_ctrl #(
  parameter int          PC_W      = 16,
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]  stall_cycles,
  output logic [15:0]  squash_count,
  output logic [15:0]  fetch_count
`endif
);
  import fetch_pkg::*;

  // Decode substitutes the package constant, so an override must agree.
  if (NOP_INSTR != fetch_pkg::NOP_INSTR) begin : g_nop_check
    $error("fetch_ctrl: NOP_INSTR differs from fetch_pkg::NOP_INSTR");
  end

  fetch_state_t    state, state_nxt;
  logic            pend;
  logic [PC_W-1:0] redir_q;
  logic            completion;
  logic            redirect_ok;
  logic            take_target;

  // A done beat wins over busy, so busy carries no extra information here.
  logic unused_busy;
  assign unused_busy = bus.mem_busy;

  assign redirect_ok = bus.redirect_in && (state != HALT);
  assign take_target = pend || redirect_ok;

  always_comb begin
    // NOTE: default first in every always_comb so no path infers a latch.
    completion = 1'b0;
    case (state)
      FETCH:   completion = bus.mem_done && !bus.stall_in;
      HOLD:    completion = !bus.stall_in;
      default: completion = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; a same-cycle redirect marks the halt as wrong-path
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (completion)        state_nxt = (bus.halt_in && !redirect_ok) ? HALT : FETCH;
        else if (bus.mem_done) state_nxt = HOLD;
      end
      HOLD: begin
        if (completion) state_nxt = (bus.halt_in && !redirect_ok) ? HALT : FETCH;
      end
      default: state_nxt = HALT;
    endcase
  end

  // Output logic
  always_comb begin
    bus.pcwren    = completion;
    bus.ifid_wren = completion;
    bus.pcselect  = completion && take_target;
    bus.if_valid  = completion && !take_target;
    bus.mem_en    = (state == FETCH) && !(bus.mem_done && bus.stall_in);
    bus.halted    = (state == HALT);
    bus.redir_pc  = redirect_ok ? bus.redirect_pc : redir_q;
  end

  // Redirect target and pending flag survive until the in-flight word lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redir_q <= '0;
      pend    <= 1'b0;
    end else begin
      if (redirect_ok) redir_q <= bus.redirect_pc;
      if (completion)       pend <= 1'b0;
      else if (redirect_ok) pend <= 1'b1;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic stall_evt, squash_evt, fetch_evt;

  assign stall_evt  = ((state == FETCH) && !bus.mem_done) || (state == HOLD);
  assign squash_evt = completion && take_target;
  assign fetch_evt  = completion && !take_target;

  fetch_perf_cnt #(.W(16)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(stall_evt), .count(stall_cycles)
  );
  fetch_perf_cnt #(.W(16)) u_squash_cnt (
    .clk(clk), .rst(rst), .inc(squash_evt), .count(squash_count)
  );
  fetch_perf_cnt #(.W(16)) u_fetch_cnt (
    .clk(clk), .rst(rst), .inc(fetch_evt), .count(fetch_count)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; output vector order in comparisons is
// {pcwren, pcselect, mem_en, ifid_wren, if_valid, halted}.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vec_count = 0;
  int   err_count = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.PC_W(16)) bus ();

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] stall_cycles, squash_count, fetch_count;
`endif

  fetch_ctrl #(.PC_W(16), .NOP_INSTR(16'h0800)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .squash_count(squash_count),
    .fetch_count(fetch_count)
`endif
  );

  wire [5:0] outs = {bus.pcwren, bus.pcselect, bus.mem_en,
                     bus.ifid_wren, bus.if_valid, bus.halted};

  task automatic clear_inputs();
    bus.stall_in    = 1'b0;
    bus.redirect_in = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_in     = 1'b0;
    bus.mem_busy    = 1'b0;
    bus.mem_done    = 1'b0;
  endtask

  // Leaves the bench 1 time unit after an edge, in cycle 1 (state IDLE).
  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    bus.mem_done = 1'b1;
    bus.stall_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b000000) begin
      err_count++;
      $display("FAIL reset_outs: got %b want %b", outs, 6'b000000);
    end
    vec_count++;
    if (bus.redir_pc !== 16'h0000) begin
      err_count++;
      $display("FAIL reset_redir: got %h want %h", bus.redir_pc, 16'h0000);
    end
`ifdef FETCH_CTRL_PERF_EN
    vec_count++;
    if ({stall_cycles, squash_count, fetch_count} !== 48'h0) begin
      err_count++;
      $display("FAIL reset_perf: got %h want %h",
               {stall_cycles, squash_count, fetch_count}, 48'h0);
    end
`endif
    bus.stall_in = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b000000) begin
      err_count++;
      $display("FAIL idle_outs: got %b want %b", outs, 6'b000000);
    end
    next_cycle();
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b101110) begin
      err_count++;
      $display("FAIL first_fetch: got %b want %b", outs, 6'b101110);
    end
    bus.mem_done = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [5:0] exp;
    do_reset();
    bus.mem_done = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      exp = (i >= 2) ? 6'b101110 : 6'b000000;
      @(negedge clk);
      vec_count++;
      if (outs !== exp) begin
        err_count++;
        $display("FAIL zero_wait_c%0d: got %b want %b", i, outs, exp);
      end
      next_cycle();
    end
    bus.mem_done = 1'b0;
`ifdef FETCH_CTRL_PERF_EN
    vec_count++;
    if (fetch_count !== 16'd9 || stall_cycles !== 16'd0) begin
      err_count++;
      $display("FAIL zero_wait_perf: got fetch=%0d stall=%0d want fetch=9 stall=0",
               fetch_count, stall_cycles);
    end
`endif
  endtask

  task automatic test_redirect_mid();
    logic [5:0] exp_outs [6];
    exp_outs = '{6'b001000, 6'b001000, 6'b111100, 6'b001000, 6'b001000, 6'b101110};
    do_reset();
    next_cycle();  // cycle 2: FETCH, access cycle 1
    for (int i = 0; i < 6; i++) begin
      bus.mem_busy    = 1'b1;
      bus.mem_done    = (i == 2) || (i == 5);
      bus.redirect_in = (i == 0);
      bus.redirect_pc = (i == 0) ? 16'h0040 : 16'hFFFF;
      @(negedge clk);
      vec_count++;
      if (outs !== exp_outs[i]) begin
        err_count++;
        $display("FAIL redir_mid_c%0d: got %b want %b", i, outs, exp_outs[i]);
      end
      if (i < 3) begin
        vec_count++;
        if (bus.redir_pc !== 16'h0040) begin
          err_count++;
          $display("FAIL redir_mid_pc_c%0d: got %h want %h", i, bus.redir_pc, 16'h0040);
        end
      end
      next_cycle();
    end
    clear_inputs();
`ifdef FETCH_CTRL_PERF_EN
    vec_count++;
    if (squash_count !== 16'd1 || fetch_count !== 16'd1 || stall_cycles !== 16'd4) begin
      err_count++;
      $display("FAIL redir_mid_perf: got sq=%0d f=%0d st=%0d want sq=1 f=1 st=4",
               squash_count, fetch_count, stall_cycles);
    end
`endif
  endtask

  task automatic test_stall();
    do_reset();
    next_cycle();  // cycle 2: FETCH
    bus.mem_done = 1'b1;
    bus.stall_in = 1'b1;
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b000000) begin
      err_count++;
      $display("FAIL stall_done: got %b want %b", outs, 6'b000000);
    end
    next_cycle();
    bus.mem_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.stall_in = (i < 3);
      @(negedge clk);
      vec_count++;
      if (dut.state !== HOLD) begin
        err_count++;
        $display("FAIL stall_hold_c%0d: got state %b want %b", i, dut.state, HOLD);
      end
      vec_count++;
      if (outs !== ((i < 3) ? 6'b000000 : 6'b100110)) begin
        err_count++;
        $display("FAIL stall_outs_c%0d: got %b want %b", i, outs,
                 (i < 3) ? 6'b000000 : 6'b100110);
      end
      next_cycle();
    end
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b001000) begin
      err_count++;
      $display("FAIL stall_after: got %b want %b", outs, 6'b001000);
    end
    clear_inputs();
  endtask

  task automatic test_redirect_halt();
    do_reset();
    next_cycle();
    bus.mem_done    = 1'b1;
    bus.halt_in     = 1'b1;
    bus.redirect_in = 1'b1;
    bus.redirect_pc = 16'h1234;
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b111100 || bus.redir_pc !== 16'h1234) begin
      err_count++;
      $display("FAIL redir_halt: got %b/%h want %b/%h", outs, bus.redir_pc,
               6'b111100, 16'h1234);
    end
    next_cycle();
    bus.halt_in     = 1'b0;
    bus.redirect_in = 1'b0;
    bus.redirect_pc = 16'h0000;
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b101110 || bus.redir_pc !== 16'h1234) begin
      err_count++;
      $display("FAIL redir_halt_next: got %b/%h want %b/%h", outs, bus.redir_pc,
               6'b101110, 16'h1234);
    end
    clear_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    next_cycle();
    bus.mem_done = 1'b1;
    bus.halt_in  = 1'b1;
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b101110) begin
      err_count++;
      $display("FAIL halt_word: got %b want %b", outs, 6'b101110);
    end
    next_cycle();
    bus.halt_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.mem_done    = i[0];
      bus.redirect_in = (i == 5);
      bus.redirect_pc = 16'hBEEF;
      @(negedge clk);
      vec_count++;
      if (outs !== 6'b000001 || bus.redir_pc !== 16'h0000) begin
        err_count++;
        $display("FAIL halt_c%0d: got %b/%h want %b/%h", i, outs, bus.redir_pc,
                 6'b000001, 16'h0000);
      end
      next_cycle();
    end
    clear_inputs();
`ifdef FETCH_CTRL_PERF_EN
    vec_count++;
    if (fetch_count !== 16'd1 || stall_cycles !== 16'd0 || squash_count !== 16'd0) begin
      err_count++;
      $display("FAIL halt_perf: got f=%0d st=%0d sq=%0d want f=1 st=0 sq=0",
               fetch_count, stall_cycles, squash_count);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    next_cycle();
    bus.mem_busy    = 1'b1;
    bus.redirect_in = 1'b1;
    bus.redirect_pc = 16'h0080;
    next_cycle();
    bus.redirect_in = 1'b0;
    @(negedge clk);
    vec_count++;
    if (dut.pend !== 1'b1 || outs !== 6'b001000 || bus.redir_pc !== 16'h0080) begin
      err_count++;
      $display("FAIL pre_reset: got pend=%b %b/%h want pend=1 %b/%h", dut.pend,
               outs, bus.redir_pc, 6'b001000, 16'h0080);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    vec_count++;
    if (outs !== 6'b000000 || bus.redir_pc !== 16'h0000 || dut.pend !== 1'b0) begin
      err_count++;
      $display("FAIL async_reset: got %b/%h pend=%b want %b/%h pend=0", outs,
               bus.redir_pc, dut.pend, 6'b000000, 16'h0000);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.mem_done = 1'b1;
    next_cycle();
    @(negedge clk);
    vec_count++;
    if (outs !== 6'b101110) begin
      err_count++;
      $display("FAIL post_reset_fetch: got %b want %b", outs, 6'b101110);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_zero_wait();
    test_redirect_mid();
    test_stall();
    test_redirect_halt();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
